mcs4_timing_gen: RTL



---
 rtl/mcs4_timing_gen.sv | 106 ++++++++++
 1 files changed

// File: rtl/mcs4_timing_gen.sv
// mcs4_timing_gen: two-phase clock, step-pulse and instruction-subcycle
// generator for the MCS-4 sequential cells.
//
// Optional feature: define TIMING_HOLD_EN to add a 'hold' input that freezes
// the generator at the end of the current subcycle (cnt == PERIOD-1).
// Without the macro the generator is free-running.
//
// All outputs are registered from the next-state values of cnt/subcycle, so
// they move on the same sysclk edge as the phase counter and have no
// combinational path from any input.

module mcs4_timing_gen #(
    parameter int PERIOD     = 8,
    parameter int PHI1_WIDTH = 2,
    parameter int PHI2_START = 4,
    parameter int PHI2_WIDTH = 2
) (
    input  logic       sysclk,
    input  logic       poc,
`ifdef TIMING_HOLD_EN
    input  logic       hold,
`endif
    output logic       clk1,
    output logic       clk2,
    output logic       phi1_step,
    output logic       phi2_step,
    output logic [2:0] subcycle,
    output logic       sync
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] PHI1_END  = CW'(PHI1_WIDTH);
    localparam logic [CW-1:0] PHI1_LAST = CW'(PHI1_WIDTH - 1);
    localparam logic [CW-1:0] PHI2_LO   = CW'(PHI2_START);
    localparam logic [CW-1:0] PHI2_HI   = CW'(PHI2_START + PHI2_WIDTH);
    localparam logic [CW-1:0] PHI2_LAST = CW'(PHI2_START + PHI2_WIDTH - 1);

    // Reject parameter sets that would break the non-overlap guarantee.
    if (PERIOD < 6) begin : g_bad_period
        $error("mcs4_timing_gen: PERIOD (%0d) must be at least 6", PERIOD);
    end
    if (PHI1_WIDTH < 1) begin : g_bad_phi1
        $error("mcs4_timing_gen: PHI1_WIDTH (%0d) must be at least 1", PHI1_WIDTH);
    end
    if (PHI1_WIDTH >= PHI2_START) begin : g_bad_phi2_start
        $error("mcs4_timing_gen: PHI1_WIDTH (%0d) must be below PHI2_START (%0d)",
               PHI1_WIDTH, PHI2_START);
    end
    if (PHI2_START + PHI2_WIDTH >= PERIOD) begin : g_bad_phi2_end
        $error("mcs4_timing_gen: PHI2_START+PHI2_WIDTH (%0d) must be below PERIOD (%0d)",
               PHI2_START + PHI2_WIDTH, PERIOD);
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    sub_nxt;
    logic          wrap;
    logic          freeze;

    // Next phase count and subcycle; a freeze parks both at the subcycle end.
    always_comb begin
        wrap    = (cnt == CNT_MAX);
`ifdef TIMING_HOLD_EN
        freeze  = hold && wrap;
`else
        freeze  = 1'b0;
`endif
        cnt_nxt = cnt;
        sub_nxt = subcycle;
        if (!freeze) begin
            if (wrap) begin
                cnt_nxt = '0;
                sub_nxt = subcycle + 3'd1;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    // State and registered output decode. Reset parks the counter at the
    // last count of X3 so the first edge after release lands on A1, cnt 0.
    // While frozen the decode of CNT_MAX already yields all phases low;
    // sync is explicitly held so a freeze never creates a sync edge.
    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            cnt       <= CNT_MAX;
            subcycle  <= 3'd7;
            clk1      <= 1'b0;
            clk2      <= 1'b0;
            phi1_step <= 1'b0;
            phi2_step <= 1'b0;
            sync      <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            subcycle  <= sub_nxt;
            clk1      <= (cnt_nxt < PHI1_END);
            clk2      <= (cnt_nxt >= PHI2_LO) && (cnt_nxt < PHI2_HI);
            phi1_step <= (cnt_nxt == PHI1_LAST);
            phi2_step <= (cnt_nxt == PHI2_LAST);
            sync      <= freeze ? sync : (sub_nxt == 3'd7);
        end
    end

endmodule
